// File: rtl/isi_channel_scheduler.sv
// Round-robin burst scheduler sharing one ISI channel; issue 1 cycle after accept, return 1 cycle after channel out.
// Backpressure: lane_ready drops while the in-flight tag FIFO is full; flush symbols separate bursts.
`timescale 1ns/1ps
module isi_channel_scheduler #(
  parameter int NUM_LANES             = 4,
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int PULSE_RESPONSE_LENGTH = 3,
  parameter int BURST_LEN             = 16,
  parameter int TAG_DEPTH             = 8,
  parameter logic [SIGNAL_RESOLUTION-1:0] FLUSH_VALUE = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_LANES-1:0]                 lane_valid,
  input  logic [NUM_LANES*SIGNAL_RESOLUTION-1:0] lane_data,
  output logic [NUM_LANES-1:0]                 lane_ready,
  output logic [SIGNAL_RESOLUTION-1:0]         ch_signal_in,
  output logic                                 ch_signal_in_valid,
  input  logic [SIGNAL_RESOLUTION-1:0]         ch_signal_out,
  input  logic                                 ch_signal_out_valid,
  output logic [SIGNAL_RESOLUTION-1:0]         out_data,
  output logic                                 out_valid,
  output logic [$clog2(NUM_LANES)-1:0]         out_lane,
  output logic                                 busy,
  output logic                                 tag_err
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int FW = $clog2(PULSE_RESPONSE_LENGTH);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;
  typedef struct packed {
    logic          flush;
    logic [LW-1:0] lane;
  } tag_t;

  state_t                       state, state_nxt;
  logic [LW-1:0]                grant, last_grant, pick, idx;
  logic                         pick_found;
  logic [BW-1:0]                burst_cnt;
  logic [FW-1:0]                flush_cnt;
  logic [AW:0]                  count;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  tag_t                         tag_mem [TAG_DEPTH];
  tag_t                         tag_head;
  logic [SIGNAL_RESOLUTION-1:0] lane_sym [NUM_LANES];
  logic                         fifo_full, fifo_empty, accept, flush_issue, push, pop;
  logic                         last_burst, last_flush;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_unpack
    assign lane_sym[g] = lane_data[g*SIGNAL_RESOLUTION +: SIGNAL_RESOLUTION];
  end

  assign fifo_full  = (count == (AW+1)'(TAG_DEPTH));
  assign fifo_empty = (count == '0);
  assign last_burst = (burst_cnt == BW'(BURST_LEN - 1));
  assign last_flush = (flush_cnt == FW'(PULSE_RESPONSE_LENGTH - 2));
  assign push       = accept | flush_issue;
  assign pop        = ch_signal_out_valid & ~fifo_empty;
  assign tag_head   = tag_mem[rd_ptr];
  assign busy       = (state != IDLE) | ~fifo_empty;

  // First valid lane strictly after last_grant, wrapping.
  always_comb begin
    pick       = last_grant;
    idx        = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = LW'((int'(last_grant) + k) % NUM_LANES);
      if (!pick_found && lane_valid[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|lane_valid) state_nxt = BURST;
      BURST:   if (!fifo_full && (!lane_valid[grant] || last_burst)) state_nxt = FLUSH;
      FLUSH:   if (!fifo_full && last_flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lane_ready  = '0;
    accept      = 1'b0;
    flush_issue = 1'b0;
    case (state)
      BURST: begin
        lane_ready[grant] = ~fifo_full;
        accept            = lane_valid[grant] & ~fifo_full;
      end
      FLUSH:   flush_issue = ~fifo_full;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant              <= '0;
      last_grant         <= LW'(NUM_LANES - 1);
      burst_cnt          <= '0;
      flush_cnt          <= '0;
      ch_signal_in       <= '0;
      ch_signal_in_valid <= 1'b0;
    end else begin
      if (state == IDLE && |lane_valid) begin
        grant      <= pick;
        last_grant <= pick;
      end
      if (state == IDLE) burst_cnt <= '0;
      else if (accept)   burst_cnt <= burst_cnt + 1'b1;
      if (state != FLUSH)   flush_cnt <= '0;
      else if (flush_issue) flush_cnt <= flush_cnt + 1'b1;
      ch_signal_in_valid <= push;
      if (accept)           ch_signal_in <= lane_sym[grant];
      else if (flush_issue) ch_signal_in <= FLUSH_VALUE;
    end
  end

  // Tag FIFO: one entry per issued symbol, retired by each channel output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= tag_t'{flush: flush_issue, lane: grant};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_lane  <= '0;
      out_valid <= 1'b0;
      tag_err   <= 1'b0;
    end else begin
      out_valid <= pop & ~tag_head.flush;
      if (pop) begin
        out_data <= ch_signal_out;
        out_lane <= tag_head.lane;
      end
      if (ch_signal_out_valid && fifo_empty) tag_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_isi_channel_scheduler.sv
// Directed bench for isi_channel_scheduler: queue-driven lanes, in-order 1-deep channel stub, logged issue/return streams.
`timescale 1ns/1ps
module tb_isi_channel_scheduler;
  localparam int NL = 4;
  localparam int SR = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NL-1:0]     lane_valid;
  logic [NL*SR-1:0]  lane_data;
  logic [NL-1:0]     lane_ready;
  logic [SR-1:0]     ch_signal_in;
  logic              ch_signal_in_valid;
  logic [SR-1:0]     ch_signal_out;
  logic              ch_signal_out_valid;
  logic [SR-1:0]     out_data;
  logic              out_valid;
  logic [1:0]        out_lane;
  logic              busy;
  logic              tag_err;

  isi_channel_scheduler dut (
    .clk(clk), .rst(rst),
    .lane_valid(lane_valid), .lane_data(lane_data), .lane_ready(lane_ready),
    .ch_signal_in(ch_signal_in), .ch_signal_in_valid(ch_signal_in_valid),
    .ch_signal_out(ch_signal_out), .ch_signal_out_valid(ch_signal_out_valid),
    .out_data(out_data), .out_valid(out_valid), .out_lane(out_lane),
    .busy(busy), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] lane_q [NL][$];
  logic [7:0] stub_q [$];
  logic [7:0] ch_log [$];
  logic [9:0] out_log [$];
  logic [7:0] exp_ch [$];
  logic [9:0] exp_out [$];
  logic [NL-1:0] pend;
  logic stub_en, inj_pulse;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor, lane sources and channel stub all act on the falling edge.
  always @(negedge clk) begin
    if (ch_signal_in_valid) ch_log.push_back(ch_signal_in);
    if (out_valid) out_log.push_back({out_lane, out_data});
    for (int i = 0; i < NL; i++) begin
      if (pend[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
      lane_valid[i] = (lane_q[i].size() > 0);
      lane_data[i*SR +: SR] = lane_valid[i] ? lane_q[i][0] : 8'h00;
    end
    pend = lane_valid & lane_ready;
    if (rst) stub_q.delete();
    else if (ch_signal_in_valid) stub_q.push_back(ch_signal_in);
    ch_signal_out_valid = 1'b0;
    if (inj_pulse) begin
      ch_signal_out_valid = 1'b1;
      ch_signal_out = 8'h55;
      inj_pulse = 1'b0;
    end else if (stub_en && stub_q.size() > 0) begin
      ch_signal_out_valid = 1'b1;
      ch_signal_out = stub_q.pop_front();
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ch_log.delete(); out_log.delete(); exp_ch.delete(); exp_out.delete();
  endtask

  task automatic wait_drain(input int maxc, input string tag);
    int n = 0;
    while ((busy || lane_q[0].size() > 0 || lane_q[1].size() > 0 || lane_q[2].size() > 0 ||
            lane_q[3].size() > 0 || stub_q.size() > 0) && n < maxc) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1 chk({tag, "_drain_tmo"}, n < maxc, 1);
  endtask

  task automatic chk_logs(input string tag);
    chk({tag, "_ch_len"}, ch_log.size(), exp_ch.size());
    for (int i = 0; i < ch_log.size() && i < exp_ch.size(); i++)
      chk($sformatf("%s_ch%0d", tag, i), ch_log[i], exp_ch[i]);
    chk({tag, "_out_len"}, out_log.size(), exp_out.size());
    for (int i = 0; i < out_log.size() && i < exp_out.size(); i++)
      chk($sformatf("%s_out%0d", tag, i), out_log[i], exp_out[i]);
  endtask

  task automatic add_burst(input int lane, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      exp_ch.push_back(8'(base + k));
      exp_out.push_back({2'(lane), 8'(base + k)});
    end
    exp_ch.push_back(8'h00);
    exp_ch.push_back(8'h00);
  endtask

  initial begin
    int n;
    rst = 1'b1; lane_valid = '0; lane_data = '0; pend = '0;
    ch_signal_out = '0; ch_signal_out_valid = 1'b0; stub_en = 1'b1; inj_pulse = 1'b0;
    #12;
    chk("rst_ready", lane_ready, 0);
    chk("rst_chin_vld", ch_signal_in_valid, 0);
    chk("rst_chin", ch_signal_in, 0);
    chk("rst_out_vld", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tag_err", tag_err, 0);

    // Single lane, 20 symbols: one full burst plus a short one.
    do_reset();
    for (int k = 1; k <= 20; k++) lane_q[0].push_back(8'(k));
    add_burst(0, 8'd1, 16);
    add_burst(0, 8'd17, 4);
    wait_drain(300, "t1");
    chk_logs("t1");
    chk("t1_busy", busy, 0);

    // Lanes 0 and 2 always valid: alternate full bursts.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      lane_q[0].push_back(8'(8'h10 + k));
      lane_q[2].push_back(8'(8'h80 + k));
    end
    add_burst(0, 8'h10, 16);
    add_burst(2, 8'h80, 16);
    add_burst(0, 8'h20, 16);
    add_burst(2, 8'h90, 16);
    wait_drain(500, "t2");
    chk_logs("t2");

    // Lane 1 ends early after 5 symbols.
    do_reset();
    for (int k = 0; k < 5; k++) lane_q[1].push_back(8'(8'h41 + k));
    add_burst(1, 8'h41, 5);
    wait_drain(100, "t3");
    chk_logs("t3");

    // Channel withholds outputs: tag FIFO fills after 8 issues.
    do_reset();
    stub_en = 1'b0;
    for (int k = 0; k < 12; k++) lane_q[0].push_back(8'(8'h61 + k));
    repeat (20) @(posedge clk);
    #1;
    chk("t4_nissue", ch_log.size(), 8);
    chk("t4_ready_full", lane_ready, 0);
    chk("t4_chvld_full", ch_signal_in_valid, 0);
    chk("t4_busy", busy, 1);
    stub_en = 1'b1;
    @(negedge clk); #1 chk("t4_ready_at_pop", lane_ready, 0);
    @(negedge clk); #1 chk("t4_ready_after_pop", lane_ready, 4'b0001);
    @(negedge clk); #1 chk("t4_resume_vld", ch_signal_in_valid, 1);
    add_burst(0, 8'h61, 12);
    wait_drain(200, "t4");
    chk_logs("t4");

    // Channel output with no tag in flight.
    do_reset();
    chk("t5_tag_err_pre", tag_err, 0);
    inj_pulse = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("t5_tag_err", tag_err, 1);
    chk("t5_out_vld", out_valid, 0);
    repeat (5) @(posedge clk);
    #1 chk("t5_tag_err_sticky", tag_err, 1);

    // Reset in the middle of a lane 0 burst with lane 1 also pending.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      lane_q[0].push_back(8'(8'h10 + k));
      lane_q[1].push_back(8'(8'h40 + k));
    end
    n = 0;
    while (ch_log.size() < 5 && n < 50) begin @(posedge clk); n++; end
    #1 chk("t6_start_tmo", n < 50, 1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("t6_rst_ready", lane_ready, 0);
    chk("t6_rst_chvld", ch_signal_in_valid, 0);
    chk("t6_rst_chin", ch_signal_in, 0);
    chk("t6_rst_outvld", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ch_log.delete(); out_log.delete();
    n = 0;
    while (out_log.size() < 1 && n < 50) begin @(posedge clk); n++; end
    #1 chk("t6_restart_tmo", n < 50, 1);
    if (ch_log.size() > 0) chk("t6_first_issue_lane0", ch_log[0][7:4], 4'h1);
    if (out_log.size() > 0) chk("t6_first_out_lane", out_log[0][9:8], 2'd0);
    lane_q[0].delete();
    lane_q[1].delete();
    wait_drain(200, "t6");
    chk("t6_tag_err", tag_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
